// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use stalls,
// taken-branch flushes and multi-cycle MUL occupancy of EX. Optional HAZARD_STATS_EN adds stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] id_instruction,
    input  logic [19:0] ex_instruction,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mul_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [3:0] ex_op, ex_rx, id_op, id_rx, id_ry, id_rz;
    logic       mul_stall, branch_fire, load_use, id_reads_ex_rx;
    logic       unused_bits;

    assign ex_op = ex_instruction[19:16];
    assign ex_rx = ex_instruction[15:12];
    assign id_op = id_instruction[19:16];
    assign id_rx = id_instruction[15:12];
    assign id_ry = id_instruction[11:8];
    assign id_rz = id_instruction[7:4];
    assign unused_bits = ^{id_instruction[3:0], ex_instruction[11:0]};

    // Which source registers the ID instruction actually reads depends on its opcode.
    always_comb begin
        id_reads_ex_rx = 1'b0;
        case (id_op)
            4'h1:                             id_reads_ex_rx = (id_ry == ex_rx);
            4'h2, 4'h8:                       id_reads_ex_rx = (id_rx == ex_rx) || (id_ry == ex_rx);
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA: id_reads_ex_rx = (id_ry == ex_rx) || (id_rz == ex_rx);
            default:                          id_reads_ex_rx = 1'b0;
        endcase
    end

    assign mul_stall = ((state_q == RUN) && (ex_op == 4'hA) && (MUL_CYCLES > 1)) ||
                       ((state_q == MUL_WAIT) && (cnt_q > 4'd1));
    assign load_use  = (ex_op == 4'h1) && (ex_rx != 4'd0) && id_reads_ex_rx;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_busy      = 1'b0;
        branch_fire   = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = RUN;
            cnt_d         = 4'd0;
        end else if (mul_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mul_busy      = 1'b1;
            if (state_q == RUN) begin
                state_d = MUL_WAIT;
                cnt_d   = MUL_LOAD;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if ((state_q == MUL_WAIT) && (cnt_q == 4'd1)) begin
            // Last MUL cycle: EX/MEM captures the product with default controls.
            state_d = RUN;
            cnt_d   = 4'd0;
        end else if ((ex_op == 4'h8) && branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            branch_fire  = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, stall_d, flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!reset && !pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
        if (branch_fire && (flush_q != 16'hFFFF))         flush_d = flush_q + 16'd1;
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
`ifdef HAZARD_STATS_EN
            stall_q <= 16'd0;
            flush_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef HAZARD_STATS_EN
            stall_q <= stall_d;
            flush_q <= flush_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (MUL_CYCLES 3 and 1) share
// stimulus; a cycle-level reference model pushes expectations that a negedge monitor checks.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] id_instruction;
    logic [19:0] ex_instruction;
    logic        branch_taken;
    logic [6:0]  outs [2];
    logic [15:0] st_out [2];
    logic [15:0] fl_out [2];

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MUL_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .id_instruction(id_instruction),
        .ex_instruction(ex_instruction), .branch_taken(branch_taken),
        .pc_write(outs[0][6]), .if_id_write(outs[0][5]), .if_id_flush(outs[0][4]),
        .id_ex_write(outs[0][3]), .id_ex_bubble(outs[0][2]), .ex_mem_bubble(outs[0][1]),
        .mul_busy(outs[0][0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(st_out[0]), .flush_count(fl_out[0])
`endif
    );

    pipeline_hazard_ctrl #(.MUL_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .id_instruction(id_instruction),
        .ex_instruction(ex_instruction), .branch_taken(branch_taken),
        .pc_write(outs[1][6]), .if_id_write(outs[1][5]), .if_id_flush(outs[1][4]),
        .id_ex_write(outs[1][3]), .id_ex_bubble(outs[1][2]), .ex_mem_bubble(outs[1][1]),
        .mul_busy(outs[1][0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(st_out[1]), .flush_count(fl_out[1])
`endif
    );

`ifndef HAZARD_STATS_EN
    assign st_out[0] = 16'd0;
    assign st_out[1] = 16'd0;
    assign fl_out[0] = 16'd0;
    assign fl_out[1] = 16'd0;
`endif

    // Output vectors: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mul_busy}
    localparam logic [6:0] EXP_DEFAULT = 7'b1101000;
    localparam logic [6:0] EXP_RESET   = 7'b0010110;
    localparam logic [6:0] EXP_MUL     = 7'b0000011;
    localparam logic [6:0] EXP_BRANCH  = 7'b1111100;
    localparam logic [6:0] EXP_LDUSE   = 7'b0001100;

    typedef struct {
        int          idx;
        logic [6:0]  e [2];
        logic [15:0] s [2];
        logic [15:0] f [2];
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          item = 0;
    int          mul_left [2] = '{0, 0};
    logic [15:0] stall_cnt [2] = '{16'd0, 16'd0};
    logic [15:0] flush_cnt [2] = '{16'd0, 16'd0};
    logic [19:0] mul_hold = 20'h0;
    int          mc [2] = '{3, 1};

    // Set of registers an instruction reads, as a 16-bit membership mask.
    function automatic logic [15:0] read_set(input logic [19:0] ins);
        logic [15:0] s;
        s = '0;
        case (ins[19:16])
            4'h1: s[ins[11:8]] = 1'b1;
            4'h2, 4'h8: begin s[ins[15:12]] = 1'b1; s[ins[11:8]] = 1'b1; end
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA: begin s[ins[11:8]] = 1'b1; s[ins[7:4]] = 1'b1; end
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic applyStimulus(input logic r, input logic [19:0] id, input logic [19:0] ex, input logic bt);
        exp_t        x;
        logic [19:0] exd;
        logic [15:0] rs;
        @(posedge clock);
        #1;
        exd = (!r && mul_left[0] > 0) ? mul_hold : ex;
        if (exd[19:16] == 4'hA) mul_hold = exd;
        reset          = r;
        id_instruction = id;
        ex_instruction = exd;
        branch_taken   = bt;
        rs             = read_set(id);
        x.idx          = item;
        item++;
        for (int k = 0; k < 2; k++) begin
            x.s[k] = stall_cnt[k];
            x.f[k] = flush_cnt[k];
            if (r) begin
                x.e[k]       = EXP_RESET;
                mul_left[k]  = 0;
                stall_cnt[k] = 16'd0;
                flush_cnt[k] = 16'd0;
            end else begin
                x.e[k] = EXP_DEFAULT;
                if (mul_left[k] > 0) begin
                    if (mul_left[k] > 1) x.e[k] = EXP_MUL;
                    mul_left[k]--;
                end else if (exd[19:16] == 4'hA) begin
                    if (mc[k] > 1) x.e[k] = EXP_MUL;
                    mul_left[k] = mc[k] - 1;
                end else if (exd[19:16] == 4'h8 && bt) begin
                    x.e[k] = EXP_BRANCH;
                    if (flush_cnt[k] != 16'hFFFF) flush_cnt[k]++;
                end else if (exd[19:16] == 4'h1 && exd[15:12] != 4'd0 && rs[exd[15:12]]) begin
                    x.e[k] = EXP_LDUSE;
                end
                if (!x.e[k][6] && stall_cnt[k] != 16'hFFFF) stall_cnt[k]++;
            end
        end
        sb.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outs[k] !== x.e[k]) begin
                errors++;
                $display("[TB] FAIL outputs mc=%0d item %0d: got %b expected %b", mc[k], x.idx, outs[k], x.e[k]);
            end
`ifdef HAZARD_STATS_EN
            checks++;
            if (st_out[k] !== x.s[k] || fl_out[k] !== x.f[k]) begin
                errors++;
                $display("[TB] FAIL stats mc=%0d item %0d: got stall %0d flush %0d expected stall %0d flush %0d",
                         mc[k], x.idx, st_out[k], fl_out[k], x.s[k], x.f[k]);
            end
`endif
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        reset          = 1'b1;
        id_instruction = 20'h0;
        ex_instruction = 20'h0;
        branch_taken   = 1'b0;
        applyStimulus(1'b1, 20'h0, 20'h0, 1'b0);
        applyStimulus(1'b1, 20'h0, 20'h0, 1'b0);
        // Load-use, then recovery with NOP in EX
        applyStimulus(1'b0, 20'h35340, 20'h13200, 1'b0);
        applyStimulus(1'b0, 20'h35340, 20'h00000, 1'b0);
        // No false hazards
        applyStimulus(1'b0, 20'h35040, 20'h10200, 1'b0);
        applyStimulus(1'b0, 20'h39000, 20'h13200, 1'b0);
        // Branch taken / not taken, and branch_taken ignored for non-branch
        applyStimulus(1'b0, 20'h00000, 20'h81200, 1'b1);
        applyStimulus(1'b0, 20'h00000, 20'h81200, 1'b0);
        applyStimulus(1'b0, 20'h00000, 20'h35340, 1'b1);
        // MUL occupancy, EX held as MUL while waiting
        applyStimulus(1'b0, 20'h00000, 20'hA5340, 1'b0);
        applyStimulus(1'b0, 20'h00000, 20'h00000, 1'b0);
        applyStimulus(1'b0, 20'h00000, 20'h00000, 1'b0);
        applyStimulus(1'b0, 20'h35340, 20'h13200, 1'b0);
        // Reset mid-MUL
        applyStimulus(1'b0, 20'h00000, 20'hA5340, 1'b0);
        applyStimulus(1'b1, 20'h00000, 20'hA5340, 1'b0);
        applyStimulus(1'b0, 20'h00000, 20'h00000, 1'b0);
        applyStimulus(1'b0, 20'h00000, 20'hA5340, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic [19:0] id, ex;
            logic [3:0]  op;
            op = 4'($urandom_range(0, 11));
            ex = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
            id = {4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
            applyStimulus($urandom_range(0, 39) == 0, id, ex, 1'($urandom));
        end
`ifdef HAZARD_STATS_EN
        for (int i = 0; i < 70000; i++) applyStimulus(1'b0, 20'h35340, 20'h13200, 1'b0);
`endif
        applyStimulus(1'b0, 20'h00000, 20'h00000, 1'b0);
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
